// File: rtl/if_types_pkg.sv
// Shared types for the OBI cache command queue front-end.
// Bus structs, cache command/result bundles, register word map.
package if_types_pkg;

   localparam int unsigned DW        = 32;
   localparam int unsigned KeyWidth  = 64;
   localparam int unsigned DataWidth = 64;
   localparam int unsigned AidWidth  = 4;

   localparam int unsigned KW = KeyWidth / DW;
   localparam int unsigned XW = DataWidth / DW;

   localparam int unsigned IdDat    = 0;
   localparam int unsigned IdKey    = XW;
   localparam int unsigned IdCtrl   = XW + KW;
   localparam int unsigned IdStatus = IdCtrl + 1;
   localparam int unsigned IdRes    = IdCtrl + 2;
   localparam int unsigned NumWords = IdRes + XW;

   localparam int unsigned CtrlStart = 0;
   localparam int unsigned CtrlOpLsb = 1;
   localparam int unsigned CtrlIrqEn = 4;

   localparam int unsigned StBusy   = 0;
   localparam int unsigned StHit    = 1;
   localparam int unsigned StDone   = 2;
   localparam int unsigned StOvf    = 3;
   localparam int unsigned StOutLsb = 4;

   typedef struct packed {
      logic                req;
      logic                we;
      logic [3:0]          be;
      logic [31:0]         addr;
      logic [DW-1:0]       wdata;
      logic [AidWidth-1:0] aid;
   } obi_req_t;

   typedef struct packed {
      logic                gnt;
      logic                rvalid;
      logic [DW-1:0]       rdata;
      logic [AidWidth-1:0] rid;
      logic                err;
   } obi_rsp_t;

   typedef struct packed {
      logic [2:0]           op;
      logic [KeyWidth-1:0]  key;
      logic [DataWidth-1:0] dat;
   } cache_cmd_t;

   typedef struct packed {
      logic [DataWidth-1:0] dat;
      logic                 hit;
   } cache_res_t;

   function automatic logic [DW-1:0] be_mask(input logic [3:0] be);
      be_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

endpackage

// File: rtl/cache_cmd_fifo.sv
// Command FIFO: circular buffer with read/write pointers and a count.
// Ports: push/din in, pop/dout out (head), full/empty flags.
module cache_cmd_fifo #(
   parameter int unsigned Depth = 4,
   parameter type         T     = logic
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  T     din,
   input  logic pop,
   output T     dout,
   output logic full,
   output logic empty
);

   localparam int unsigned PW = $clog2(Depth);
   localparam int unsigned CW = $clog2(Depth + 1);

   T              mem [Depth];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == CW'(Depth));
   assign empty   = (cnt == '0);
   assign dout    = mem[rd_ptr];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      nxt = (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < Depth; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= nxt(wr_ptr);
         end
         if (do_pop) rd_ptr <= nxt(rd_ptr);
         unique case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/obi_cache_cmd_queue_if.sv
// OBI register front-end queuing cache commands and capturing results.
// Ports: obi_req/obi_resp bus, cmd_* to controller, res_* back, irq_o.
module obi_cache_cmd_queue_if
   import if_types_pkg::*;
#(
   parameter int unsigned QueueDepth = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  obi_req_t   obi_req,
   output obi_rsp_t   obi_resp,
   output logic       cmd_valid_o,
   input  logic       cmd_ready_i,
   output cache_cmd_t cmd_o,
   input  logic       res_valid_i,
   input  cache_res_t res_i,
   output logic       irq_o
);

   logic [DW-1:0] dat_q [XW];
   logic [DW-1:0] key_q [KW];
   logic [DW-1:0] res_q [XW];
   logic [2:0]    op_q;
   logic          irq_en_q;
   logic          hit_q;
   logic          done_q;
   logic          ovf_q;
   logic [3:0]    outst_q;

   logic                rvalid_q;
   logic                err_q;
   logic [DW-1:0]       rdata_q;
   logic [AidWidth-1:0] rid_q;

   logic [31:0]    widx;
   logic           unused_addr_lsb;
   logic           wr_req;
   logic           rd_req;
   logic           mapped;
   logic           hit_ctrl;
   logic           hit_stat;
   logic           hit_res;
   logic           start_req;
   logic           reject;
   logic           err_d;
   logic           wr_ok;
   logic           push;
   logic           pop;
   logic           full;
   logic           empty;
   logic           res_acc;
   logic           clr_done;
   logic           clr_ovf;
   logic [DW-1:0]  wmask;
   logic [DW-1:0]  rdata_d;
   logic [DW-1:0]  ctrl_word;
   logic [DW-1:0]  stat_word;
   cache_cmd_t     push_cmd;

   assign widx            = {2'b00, obi_req.addr[31:2]};
   assign unused_addr_lsb = ^obi_req.addr[1:0];
   assign wr_req          = obi_req.req & obi_req.we;
   assign rd_req          = obi_req.req & ~obi_req.we;
   assign mapped          = widx < NumWords;
   assign hit_ctrl        = widx == IdCtrl;
   assign hit_stat        = widx == IdStatus;
   assign hit_res         = mapped & (widx >= IdRes);
   assign wmask           = be_mask(obi_req.be);

   assign start_req = wr_req & hit_ctrl & obi_req.be[0]
                    & obi_req.wdata[CtrlStart];
   // A pop this cycle does not free a slot for a start.
   assign reject    = start_req & full;
   assign err_d     = obi_req.req
                    & (~mapped | (wr_req & hit_res) | reject);
   assign wr_ok     = wr_req & ~err_d;
   assign push      = start_req & ~reject;
   assign pop       = cmd_valid_o & cmd_ready_i;
   assign res_acc   = res_valid_i & (outst_q != '0);

   assign clr_done = wr_ok & hit_stat & obi_req.be[0]
                   & obi_req.wdata[StDone];
   assign clr_ovf  = wr_ok & hit_stat & obi_req.be[0]
                   & obi_req.wdata[StOvf];

   always_comb begin
      push_cmd    = '0;
      push_cmd.op = obi_req.wdata[CtrlOpLsb +: 3];
      for (int unsigned i = 0; i < KW; i++)
         push_cmd.key[i*DW +: DW] = key_q[i];
      for (int unsigned i = 0; i < XW; i++)
         push_cmd.dat[i*DW +: DW] = dat_q[i];
   end

   always_comb begin
      ctrl_word                    = '0;
      ctrl_word[CtrlOpLsb +: 3]    = op_q;
      ctrl_word[CtrlIrqEn]         = irq_en_q;
      stat_word                    = '0;
      stat_word[StBusy]            = outst_q != '0;
      stat_word[StHit]             = hit_q;
      stat_word[StDone]            = done_q;
      stat_word[StOvf]             = ovf_q;
      stat_word[StOutLsb +: 4]     = outst_q;
   end

   // Read data reflects register state before this cycle's write.
   always_comb begin
      rdata_d = '0;
      if (rd_req) begin
         for (int unsigned i = 0; i < XW; i++)
            if (widx == IdDat + i) rdata_d = dat_q[i];
         for (int unsigned i = 0; i < KW; i++)
            if (widx == IdKey + i) rdata_d = key_q[i];
         if (hit_ctrl) rdata_d = ctrl_word;
         if (hit_stat) rdata_d = stat_word;
         for (int unsigned i = 0; i < XW; i++)
            if (widx == IdRes + i) rdata_d = res_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         rid_q    <= '0;
      end else begin
         rvalid_q <= obi_req.req;
         err_q    <= err_d;
         rdata_q  <= err_d ? '0 : rdata_d;
         if (obi_req.req) rid_q <= obi_req.aid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < XW; i++) dat_q[i] <= '0;
         for (int unsigned i = 0; i < KW; i++) key_q[i] <= '0;
         for (int unsigned i = 0; i < XW; i++) res_q[i] <= '0;
         op_q     <= '0;
         irq_en_q <= 1'b0;
         hit_q    <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         outst_q  <= '0;
      end else begin
         for (int unsigned i = 0; i < XW; i++)
            if (wr_ok && widx == IdDat + i)
               dat_q[i] <= (dat_q[i] & ~wmask)
                         | (obi_req.wdata & wmask);
         for (int unsigned i = 0; i < KW; i++)
            if (wr_ok && widx == IdKey + i)
               key_q[i] <= (key_q[i] & ~wmask)
                         | (obi_req.wdata & wmask);
         if (wr_ok && hit_ctrl && obi_req.be[0]) begin
            op_q     <= obi_req.wdata[CtrlOpLsb +: 3];
            irq_en_q <= obi_req.wdata[CtrlIrqEn];
         end
         if (res_acc) begin
            for (int unsigned i = 0; i < XW; i++)
               res_q[i] <= res_i.dat[i*DW +: DW];
            hit_q <= res_i.hit;
         end
         // A result arriving together with a W1C keeps done set.
         if (res_acc)       done_q <= 1'b1;
         else if (clr_done) done_q <= 1'b0;
         if (reject)        ovf_q <= 1'b1;
         else if (clr_ovf)  ovf_q <= 1'b0;
         unique case ({push, res_acc})
            2'b10:   outst_q <= outst_q + 4'd1;
            2'b01:   outst_q <= outst_q - 4'd1;
            default: outst_q <= outst_q;
         endcase
      end
   end

   cache_cmd_fifo #(
      .Depth (QueueDepth),
      .T     (cache_cmd_t)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (push_cmd),
      .pop   (pop),
      .dout  (cmd_o),
      .full  (full),
      .empty (empty)
   );

   assign cmd_valid_o     = ~empty;
   assign irq_o           = done_q & irq_en_q;
   assign obi_resp.gnt    = obi_req.req;
   assign obi_resp.rvalid = rvalid_q;
   assign obi_resp.rdata  = rdata_q;
   assign obi_resp.rid    = rid_q;
   assign obi_resp.err    = err_q;

endmodule
